csi2_tx_lane_ctrl: RTL

- Sequences the two-lane D-PHY transmit model.
- Accepts a byte-serial CSI-2 packet stream (valid/ready with sop/eop) from the packet builder.
- Raises txrequest_hs and waits for txready_hs, then packs consecutive bytes onto lane0/lane1, one beat per byte pair.
- Closes the HS burst and enforces a minimum LP gap before the next packet.
- Sits between the packet builder and the D-PHY model; it drives all of the model's request/data inputs.

---
 rtl/csi2_ctrl_pkg.sv | 23 ++
 rtl/csi2_byte_pair.sv | 66 ++++++
 rtl/csi2_tx_lane_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/csi2_ctrl_pkg.sv
// Shared types and defaults for the two-lane CSI-2 transmit lane controller.
package csi2_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StXfer,
    StGap
  } state_e;

  localparam int unsigned LpGapCycDefault     = 8;
  localparam int unsigned ReadyTimeoutDefault = 64;

  typedef struct packed {
    logic [7:0] lane0;
    logic [7:0] lane1;
    logic       v0;
    logic       v1;
    logic       sop;
    logic       eop;
  } beat_t;

endpackage

// File: rtl/csi2_byte_pair.sv
// Pairs even/odd bytes of a packet into one registered two-lane beat.
module csi2_byte_pair
  import csi2_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] byte_i,
  input  logic       accept_i,
  input  logic       first_i,
  input  logic       last_i,
  output beat_t      beat_o
);

  logic       odd_q, odd_d;
  logic [7:0] held_q, held_d;
  logic       held_first_q, held_first_d;
  beat_t      beat_q, beat_d;

  always_comb begin
    odd_d        = odd_q;
    held_d       = held_q;
    held_first_d = held_first_q;
    beat_d       = '0;
    if (accept_i) begin
      if (odd_q) begin
        beat_d.lane0 = held_q;
        beat_d.lane1 = byte_i;
        beat_d.v0    = 1'b1;
        beat_d.v1    = 1'b1;
        beat_d.sop   = held_first_q;
        beat_d.eop   = last_i;
        odd_d        = 1'b0;
      end else begin
        held_d       = byte_i;
        held_first_d = first_i;
        // A last byte on an even index closes the packet as a half beat.
        if (last_i) begin
          beat_d.lane0 = byte_i;
          beat_d.v0    = 1'b1;
          beat_d.sop   = first_i;
          beat_d.eop   = 1'b1;
          odd_d        = 1'b0;
        end else begin
          odd_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      odd_q        <= 1'b0;
      held_q       <= '0;
      held_first_q <= 1'b0;
      beat_q       <= '0;
    end else begin
      odd_q        <= odd_d;
      held_q       <= held_d;
      held_first_q <= held_first_d;
      beat_q       <= beat_d;
    end
  end

  assign beat_o = beat_q;

endmodule

// File: rtl/csi2_tx_lane_ctrl.sv
// Sequences HS request/ready handshake, byte pairing onto two lanes and the LP gap.
// Error pulses are registered and appear the cycle after the offending event.
module csi2_tx_lane_ctrl
  import csi2_ctrl_pkg::*;
#(
  parameter int unsigned LP_GAP_CYC    = LpGapCycDefault,
  parameter int unsigned READY_TIMEOUT = ReadyTimeoutDefault,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_sop,
  input  logic       s_eop,
  output logic       s_ready,
  input  logic       txready_hs,
  output logic       txrequest_hs,
  output logic       txwrite_hs,
  output logic [7:0] lane0_byte,
  output logic       lane0_valid,
  output logic [7:0] lane1_byte,
  output logic       lane1_valid,
  output logic       sop,
  output logic       eop,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_proto
);

  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(LP_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] ToutLast = CNT_W'(READY_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             first_q, first_d;
  logic             done_q, done_d;
  logic             txreq_q, txreq_d;
  logic             err_to_q, err_to_d;
  logic             err_pr_q, err_pr_d;
  logic             xfer_accept;
  beat_t            beat;

  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign xfer_accept = (state_q == StXfer) & ~done_q & s_valid & txready_hs;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    done_d   = done_q;
    s_ready  = 1'b0;
    err_to_d = 1'b0;
    err_pr_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Stray non-sop bytes are drained so the builder cannot wedge us.
        s_ready  = s_valid & ~s_sop;
        err_pr_d = s_valid & ~s_sop;
        if (s_valid && s_sop) begin
          state_d = StReq;
          cnt_d   = '0;
        end
      end
      StReq: begin
        if (txready_hs) begin
          state_d = StXfer;
          first_d = 1'b1;
          done_d  = 1'b0;
        end else if (READY_TIMEOUT != 0 && cnt_q >= ToutLast) begin
          state_d  = StGap;
          cnt_d    = '0;
          err_to_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StXfer: begin
        if (done_q) begin
          // Eop beat is on the lanes this cycle; close the burst next edge.
          state_d = StGap;
          cnt_d   = '0;
          done_d  = 1'b0;
        end else begin
          s_ready = txready_hs;
          if (xfer_accept) begin
            first_d  = 1'b0;
            err_pr_d = s_sop & ~first_q;
            if (s_eop) done_d = 1'b1;
          end
        end
      end
      StGap: begin
        if (cnt_q >= GapLast) state_d = StIdle;
        else                  cnt_d   = cnt_inc;
      end
      default: state_d = StIdle;
    endcase
    txreq_d = (state_d == StReq) | (state_d == StXfer);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      done_q   <= 1'b0;
      txreq_q  <= 1'b0;
      err_to_q <= 1'b0;
      err_pr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      done_q   <= done_d;
      txreq_q  <= txreq_d;
      err_to_q <= err_to_d;
      err_pr_q <= err_pr_d;
    end
  end

  csi2_byte_pair u_pair (
    .clk      (clk),
    .resetn   (resetn),
    .byte_i   (s_data),
    .accept_i (xfer_accept),
    .first_i  (first_q),
    .last_i   (s_eop),
    .beat_o   (beat)
  );

  assign txrequest_hs = txreq_q;
  assign txwrite_hs   = beat.v0;
  assign lane0_byte   = beat.lane0;
  assign lane0_valid  = beat.v0;
  assign lane1_byte   = beat.lane1;
  assign lane1_valid  = beat.v1;
  assign sop          = beat.sop;
  assign eop          = beat.eop;
  assign busy         = (state_q != StIdle);
  assign err_timeout  = err_to_q;
  assign err_proto    = err_pr_q;

endmodule
